control_code_gen: RTL and testbench
===================================

CONTROL_CODE_GEN -- requirements
Module: control_code_gen

Interface
REQ-001 Parameter HALT_OC, default 8'hFF: the opcode that stops the sequencer.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 OC  in  8  current opcode from IR; stable from the cycle after L_IR until the next L_IR.
REQ-006 FL  in  1  condition flag from flag register, valid during EXEC.
REQ-007 L_IR  out  1  load IR from program memory.
REQ-008 I_PC / L_PC  out  1 each  PC increment / PC load.
REQ-009 S11,S10  out  1 each  PC load source: 00 OR2, 01 R0, 10 DM.
REQ-010 enab  out  2  register write enables: [0] write destination register, [1] reserved, always 0.
REQ-011 mux_sel  out  2  register write source: 00 ALU, 01 DM, 10 OR2, 11 R0.
REQ-012 S_AL  out  1  flag register update strobe.
REQ-013 S_AF  out  4  ALU function code.
REQ-014 sel_a, sel_b  out  1 each  ALU operand selects.
REQ-015 RD, WR  out  1 each  data-memory read / write strobes.
REQ-016 S2  out  1  data-memory address select: 0 R_N, 1 stack pointer.
REQ-017 S5  out  1  data-memory write-data select: 0 R0, 1 NPC.
REQ-018 rw  out  2  stack pointer command: 00 hold, 01 push (decrement), 10 pop (increment), 11 never driven.
REQ-019 halted  out  1  high while in HALT.
REQ-020 instr_cnt  out  8  count of retired instructions.

Function
REQ-021 States SHALL be FETCH, EXEC, MEM, HALT, held in a state register.
REQ-022 Outputs SHALL be decoded combinationally from state and OC; any output not listed for a state/class is 0.
REQ-023 FETCH: L_IR=1 and I_PC=1; next state is EXEC.
REQ-024 The class is OC[7:4].
REQ-025 Class 0x0-0x9 (ALU), EXEC: S_AF=OC[7:4], sel_a=OC[3], sel_b=OC[2], S_AL=1, enab=01, mux_sel=00; next state is FETCH.
REQ-026 Class 0xA (LOAD): EXEC drives RD=1, S2=0; MEM drives RD=1, S2=0, enab=01, mux_sel=01; then FETCH.
REQ-027 Class 0xB (STORE), EXEC: WR=1, S2=0, S5=0; next state is FETCH.
REQ-028 Class 0xC (JMPcond), EXEC: if FL=1 then L_PC=1, S11S10=00; otherwise no PC action; next state is FETCH.
REQ-029 Class 0xD (CALL): EXEC drives WR=1, S2=1, S5=1, rw=01; MEM drives L_PC=1, S11S10=00; then FETCH.
REQ-030 Class 0xE (RET): EXEC drives RD=1, S2=1; MEM drives RD=1, S2=1, L_PC=1, S11S10=10, rw=10; then FETCH.
REQ-031 Class 0xF: if OC==HALT_OC, EXEC goes to HALT; otherwise it is a NOP and returns to FETCH.
REQ-032 HALT is absorbing: all strobes are 0 and halted=1; only rst exits HALT.
REQ-033 instr_cnt SHALL increment on the last cycle of each instruction (EXEC for 1-cycle classes, MEM for 2-cycle classes).
REQ-034 instr_cnt wraps 8'hFF to 8'h00.
REQ-035 The HALT instruction itself SHALL count as retired.
REQ-036 L_PC and I_PC SHALL never be asserted in the same cycle.
REQ-037 RD and WR SHALL never be asserted in the same cycle.

Reset
REQ-038 While rst=1, all outputs SHALL be 0, including halted and instr_cnt.
REQ-039 On the first edge with rst=0, the state SHALL be FETCH.
REQ-040 rst asserted in any state, including mid-MEM or HALT, SHALL abort the instruction with no further strobes and return to FETCH after release.

Verification
REQ-041 Reset release, OC=8'h3C -> FETCH (L_IR=1, I_PC=1); then EXEC with S_AF=3, sel_a=1, sel_b=1, S_AL=1, enab=01, mux_sel=00; instr_cnt=1.
REQ-042 OC=8'hC0: with FL=0 -> no L_PC; with FL=1 -> L_PC=1, S11S10=00 in EXEC; each takes 2 cycles.
REQ-043 CALL then RET -> CALL EXEC: WR=1, S5=1, S2=1, rw=01; CALL MEM: L_PC=1; RET MEM: L_PC=1, S11S10=10, rw=10; instr_cnt +2.
REQ-044 OC=8'hFF -> HALT, halted=1, all strobes 0 for 20 cycles; rst pulse -> FETCH, instr_cnt=0.
REQ-045 256 ALU instructions from reset -> instr_cnt wraps to 8'h00.
REQ-046 rst asserted during LOAD MEM -> no enab write on that cycle; FETCH follows release.

Source files
------------

// File: rtl/control_code_gen.sv
// Control-code generator for a small accumulator/stack CPU: sequences
// FETCH/EXEC/MEM/HALT and decodes all datapath strobes from state and opcode.
module control_code_gen #(
  parameter logic [7:0] HALT_OC = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] OC,
  input  logic       FL,
  output logic       L_IR,
  output logic       I_PC,
  output logic       L_PC,
  output logic       S11,
  output logic       S10,
  output logic [1:0] enab,
  output logic [1:0] mux_sel,
  output logic       S_AL,
  output logic [3:0] S_AF,
  output logic       sel_a,
  output logic       sel_b,
  output logic       RD,
  output logic       WR,
  output logic       S2,
  output logic       S5,
  output logic [1:0] rw,
  output logic       halted,
  output logic [7:0] instr_cnt
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    MEM   = 2'b10,
    HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic       l_ir;
    logic       i_pc;
    logic       l_pc;
    logic       s11;
    logic       s10;
    logic [1:0] enab;
    logic [1:0] mux_sel;
    logic       s_al;
    logic [3:0] s_af;
    logic       sel_a;
    logic       sel_b;
    logic       rd;
    logic       wr;
    logic       s2;
    logic       s5;
    logic [1:0] rw;
    logic       halted;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [7:0] instr_cnt_q, instr_cnt_d;
  logic [3:0] cls_s;
  logic       retire_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_o_s;

  assign cls_s = OC[7:4];

  // Next-state, retire pulse and strobe decode from state and opcode class
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    ctrl_s   = '0;
    case (state_q)
      FETCH: begin
        ctrl_s.l_ir = 1'b1;
        ctrl_s.i_pc = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        case (cls_s)
          4'hA: begin
            ctrl_s.rd = 1'b1;
            ctrl_s.s2 = 1'b0;
            state_d   = MEM;
          end
          4'hB: begin
            ctrl_s.wr = 1'b1;
            ctrl_s.s2 = 1'b0;
            ctrl_s.s5 = 1'b0;
            state_d   = FETCH;
            retire_s  = 1'b1;
          end
          4'hC: begin
            if (FL) begin
              ctrl_s.l_pc = 1'b1;
              ctrl_s.s11  = 1'b0;
              ctrl_s.s10  = 1'b0;
            end else begin
              ctrl_s.l_pc = 1'b0;
            end
            state_d  = FETCH;
            retire_s = 1'b1;
          end
          4'hD: begin
            ctrl_s.wr = 1'b1;
            ctrl_s.s2 = 1'b1;
            ctrl_s.s5 = 1'b1;
            ctrl_s.rw = 2'b01;
            state_d   = MEM;
          end
          4'hE: begin
            ctrl_s.rd = 1'b1;
            ctrl_s.s2 = 1'b1;
            state_d   = MEM;
          end
          4'hF: begin
            if (OC == HALT_OC) begin
              state_d = HALT;
            end else begin
              state_d = FETCH;
            end
            retire_s = 1'b1;
          end
          default: begin
            // Classes 0x0-0x9: the class doubles as the ALU function code
            ctrl_s.s_af    = cls_s;
            ctrl_s.sel_a   = OC[3];
            ctrl_s.sel_b   = OC[2];
            ctrl_s.s_al    = 1'b1;
            ctrl_s.enab    = 2'b01;
            ctrl_s.mux_sel = 2'b00;
            state_d        = FETCH;
            retire_s       = 1'b1;
          end
        endcase
      end
      MEM: begin
        state_d = FETCH;
        case (cls_s)
          4'hA: begin
            ctrl_s.rd      = 1'b1;
            ctrl_s.s2      = 1'b0;
            ctrl_s.enab    = 2'b01;
            ctrl_s.mux_sel = 2'b01;
            retire_s       = 1'b1;
          end
          4'hD: begin
            ctrl_s.l_pc = 1'b1;
            ctrl_s.s11  = 1'b0;
            ctrl_s.s10  = 1'b0;
            retire_s    = 1'b1;
          end
          4'hE: begin
            ctrl_s.rd   = 1'b1;
            ctrl_s.s2   = 1'b1;
            ctrl_s.l_pc = 1'b1;
            ctrl_s.s11  = 1'b1;
            ctrl_s.s10  = 1'b0;
            ctrl_s.rw   = 2'b10;
            retire_s    = 1'b1;
          end
          default: begin
            retire_s = 1'b0;
          end
        endcase
      end
      HALT: begin
        ctrl_s.halted = 1'b1;
        state_d       = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Retired-instruction counter next value, wrapping naturally at 8 bits
  always_comb begin
    if (retire_s) begin
      instr_cnt_d = instr_cnt_q + 8'd1;
    end else begin
      instr_cnt_d = instr_cnt_q;
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      instr_cnt_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // rst silences every output in the same cycle, so an aborted MEM writes nothing
  always_comb begin
    if (rst) begin
      ctrl_o_s = '0;
    end else begin
      ctrl_o_s = ctrl_s;
    end
  end

  assign L_IR      = ctrl_o_s.l_ir;
  assign I_PC      = ctrl_o_s.i_pc;
  assign L_PC      = ctrl_o_s.l_pc;
  assign S11       = ctrl_o_s.s11;
  assign S10       = ctrl_o_s.s10;
  assign enab      = ctrl_o_s.enab;
  assign mux_sel   = ctrl_o_s.mux_sel;
  assign S_AL      = ctrl_o_s.s_al;
  assign S_AF      = ctrl_o_s.s_af;
  assign sel_a     = ctrl_o_s.sel_a;
  assign sel_b     = ctrl_o_s.sel_b;
  assign RD        = ctrl_o_s.rd;
  assign WR        = ctrl_o_s.wr;
  assign S2        = ctrl_o_s.s2;
  assign S5        = ctrl_o_s.s5;
  assign rw        = ctrl_o_s.rw;
  assign halted    = ctrl_o_s.halted;
  assign instr_cnt = rst ? 8'h00 : instr_cnt_q;

endmodule

// File: tb/tb_control_code_gen.sv
// Scoreboard bench for control_code_gen: the stimulus queues per-cycle expected
// outputs, and a negedge monitor pops and compares them.
module tb_control_code_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] OC  = 8'h00;
  logic       FL  = 1'b0;
  logic       L_IR, I_PC, L_PC, S11, S10, S_AL, sel_a, sel_b, RD, WR, S2, S5, halted;
  logic [1:0] enab, mux_sel, rw;
  logic [3:0] S_AF;
  logic [7:0] instr_cnt;

  // Bit fields of the 23-bit strobe vector, MSB L_IR down to LSB halted
  localparam logic [22:0] F_LIR  = 23'h400000;
  localparam logic [22:0] F_IPC  = 23'h200000;
  localparam logic [22:0] F_LPC  = 23'h100000;
  localparam logic [22:0] F_S11  = 23'h080000;
  localparam logic [22:0] F_EN0  = 23'h010000;
  localparam logic [22:0] F_MXDM = 23'h004000;
  localparam logic [22:0] F_SAL  = 23'h002000;
  localparam logic [22:0] F_AF3  = 23'h000600;
  localparam logic [22:0] F_AF5  = 23'h000A00;
  localparam logic [22:0] F_AF9  = 23'h001200;
  localparam logic [22:0] F_SELA = 23'h000100;
  localparam logic [22:0] F_SELB = 23'h000080;
  localparam logic [22:0] F_RD   = 23'h000040;
  localparam logic [22:0] F_WR   = 23'h000020;
  localparam logic [22:0] F_S2   = 23'h000010;
  localparam logic [22:0] F_S5   = 23'h000008;
  localparam logic [22:0] F_POP  = 23'h000004;
  localparam logic [22:0] F_PUSH = 23'h000002;
  localparam logic [22:0] F_HALT = 23'h000001;
  localparam logic [22:0] P_NONE = 23'h000000;
  localparam logic [22:0] P_FETCH = F_LIR | F_IPC;

  typedef struct {
    string       nm;
    logic [30:0] v;
  } exp_t;

  exp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] cnt_m    = 8'h00;

  control_code_gen #(.HALT_OC(8'hFF)) dut (
    .clk(clk), .rst(rst), .OC(OC), .FL(FL),
    .L_IR(L_IR), .I_PC(I_PC), .L_PC(L_PC), .S11(S11), .S10(S10),
    .enab(enab), .mux_sel(mux_sel), .S_AL(S_AL), .S_AF(S_AF),
    .sel_a(sel_a), .sel_b(sel_b), .RD(RD), .WR(WR), .S2(S2), .S5(S5),
    .rw(rw), .halted(halted), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: one output set per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t        e;
    logic [30:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {L_IR, I_PC, L_PC, S11, S10, enab, mux_sel, S_AL, S_AF,
             sel_a, sel_b, RD, WR, S2, S5, rw, halted, instr_cnt};
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got strobes=%h cnt=%h, expected strobes=%h cnt=%h",
                 e.nm, act[30:8], act[7:0], e.v[30:8], e.v[7:0]);
      end
    end
  end

  task automatic step(input logic [7:0] oc, input logic fl, input logic r,
                      input logic [22:0] p, input string nm);
    exp_t e;
    OC   = oc;
    FL   = fl;
    rst  = r;
    e.nm = nm;
    e.v  = {p, (r ? 8'h00 : cnt_m)};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) cnt_m = 8'h00;
  endtask

  task automatic run1(input logic [7:0] oc, input logic fl, input logic [22:0] ex, input string nm);
    step(oc, fl, 1'b0, P_FETCH, {nm, "_fetch"});
    step(oc, fl, 1'b0, ex, {nm, "_exec"});
    cnt_m = cnt_m + 8'd1;
  endtask

  task automatic run2(input logic [7:0] oc, input logic [22:0] ex, input logic [22:0] mem, input string nm);
    step(oc, 1'b0, 1'b0, P_FETCH, {nm, "_fetch"});
    step(oc, 1'b0, 1'b0, ex, {nm, "_exec"});
    step(oc, 1'b0, 1'b0, mem, {nm, "_mem"});
    cnt_m = cnt_m + 8'd1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    step(8'h3C, 1'b0, 1'b1, P_NONE, "reset0");
    step(8'h3C, 1'b1, 1'b1, P_NONE, "reset1");

    run1(8'h3C, 1'b0, F_AF3 | F_SELA | F_SELB | F_SAL | F_EN0, "alu3c");
    run1(8'h58, 1'b0, F_AF5 | F_SELA | F_SAL | F_EN0, "alu58");
    run1(8'h94, 1'b0, F_AF9 | F_SELB | F_SAL | F_EN0, "alu94");
    run1(8'hC0, 1'b0, P_NONE, "jmp_fl0");
    run1(8'hC0, 1'b1, F_LPC, "jmp_fl1");
    run2(8'hA5, F_RD, F_RD | F_EN0 | F_MXDM, "load");
    run1(8'hB0, 1'b0, F_WR, "store");
    run2(8'hD0, F_WR | F_S2 | F_S5 | F_PUSH, F_LPC, "call");
    run2(8'hE0, F_RD | F_S2, F_RD | F_S2 | F_LPC | F_S11 | F_POP, "ret");
    run1(8'hF0, 1'b0, P_NONE, "nop");

    run1(8'hFF, 1'b0, P_NONE, "halt_instr");
    for (int i = 0; i < 20; i++) begin
      step(8'h3C + 8'(i), 1'b1, 1'b0, F_HALT, "halted");
    end
    step(8'h3C, 1'b0, 1'b1, P_NONE, "halt_rst");
    step(8'h3C, 1'b0, 1'b0, P_FETCH, "post_halt_fetch");
    step(8'h3C, 1'b0, 1'b0, F_AF3 | F_SELA | F_SELB | F_SAL | F_EN0, "post_halt_exec");
    cnt_m = cnt_m + 8'd1;

    step(8'hA5, 1'b0, 1'b0, P_FETCH, "abort_fetch");
    step(8'hA5, 1'b0, 1'b0, F_RD, "abort_exec");
    step(8'hA5, 1'b0, 1'b1, P_NONE, "abort_mem_rst");
    run1(8'h3C, 1'b0, F_AF3 | F_SELA | F_SELB | F_SAL | F_EN0, "after_abort");

    step(8'h3C, 1'b0, 1'b1, P_NONE, "wrap_rst");
    for (int i = 0; i < 256; i++) begin
      run1(8'h3C, 1'b0, F_AF3 | F_SELA | F_SELB | F_SAL | F_EN0, "wrap_alu");
    end
    step(8'h3C, 1'b0, 1'b0, P_FETCH, "wrap_cnt_zero");

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
